// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared port encoding and constants for the register-file writeback arbiter
package rf_wb_pkg;
  typedef enum logic {RF_WB_PORT0, RF_WB_PORT1} rf_wb_port_t;
  localparam int RF_WB_ZERO_ADDR = 0;
endpackage

// File: rtl/rf_wb_rr_arb.sv
// rf_wb_rr_arb: two-input round-robin arbiter; pointer names the preferred stream on contention
module rf_wb_rr_arb
  import rf_wb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic val0_i,
  input  logic val1_i,
  output logic grant0_o,
  output logic grant1_o
);
  rf_wb_port_t ptr_q, ptr_d;
  assign grant0_o = val0_i && (!val1_i || ptr_q == RF_WB_PORT0);
  assign grant1_o = val1_i && (!val0_i || ptr_q == RF_WB_PORT1);
  // every grant outside reset is a transfer, so the winner hands priority to the other stream
  always_comb begin
    ptr_d = grant0_o ? RF_WB_PORT1 : grant1_o ? RF_WB_PORT0 : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= RF_WB_PORT0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges two writeback streams onto one registered regfile write port.
// Define RF_WB_BYPASS_EN to forward the staged write onto the read data outputs.
module rf_writeback_arbiter
  import rf_wb_pkg::*;
#(
  parameter  int p_data_nbits  = 32,
  parameter  int p_num_entries = 32,
  parameter  int p_zero_reg    = 1,
  localparam int c_addr_nbits  = $clog2(p_num_entries)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in0_val,
  output logic                    in0_rdy,
  input  logic [c_addr_nbits-1:0] in0_addr,
  input  logic [p_data_nbits-1:0] in0_data,
  input  logic                    in1_val,
  output logic                    in1_rdy,
  input  logic [c_addr_nbits-1:0] in1_addr,
  input  logic [p_data_nbits-1:0] in1_data,
  output logic                    write_en,
  output logic [c_addr_nbits-1:0] write_addr,
  output logic [p_data_nbits-1:0] write_data,
  input  logic [c_addr_nbits-1:0] read_addr0,
  input  logic [c_addr_nbits-1:0] read_addr1,
  input  logic [p_data_nbits-1:0] rf_read_data0,
  input  logic [p_data_nbits-1:0] rf_read_data1,
  output logic [p_data_nbits-1:0] read_data0,
  output logic [p_data_nbits-1:0] read_data1
);
  localparam logic [c_addr_nbits-1:0] c_zero = c_addr_nbits'(RF_WB_ZERO_ADDR);
  logic                    grant0, grant1, xfer;
  logic [c_addr_nbits-1:0] sel_addr;
  logic [p_data_nbits-1:0] sel_data;
  logic                    write_en_q, write_en_d;
  logic [c_addr_nbits-1:0] write_addr_q, write_addr_d;
  logic [p_data_nbits-1:0] write_data_q, write_data_d;
  rf_wb_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .val0_i  (in0_val),
    .val1_i  (in1_val),
    .grant0_o(grant0),
    .grant1_o(grant1)
  );
  assign in0_rdy  = grant0 && !reset;
  assign in1_rdy  = grant1 && !reset;
  assign xfer     = in0_rdy || in1_rdy;
  assign sel_addr = grant1 ? in1_addr : in0_addr;
  assign sel_data = grant1 ? in1_data : in0_data;
  // a write to r0 is still accepted upstream, it just never reaches the regfile
  always_comb begin
    write_en_d   = xfer && !(p_zero_reg != 0 && sel_addr == c_zero);
    write_addr_d = xfer ? sel_addr : write_addr_q;
    write_data_d = xfer ? sel_data : write_data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end
  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
`ifdef RF_WB_BYPASS_EN
  assign read_data0 = (write_en_q && write_addr_q == read_addr0 && !(p_zero_reg != 0 && read_addr0 == c_zero))
                      ? write_data_q : rf_read_data0;
  assign read_data1 = (write_en_q && write_addr_q == read_addr1 && !(p_zero_reg != 0 && read_addr1 == c_zero))
                      ? write_data_q : rf_read_data1;
`else
  logic unused_read_addr;
  assign unused_read_addr = ^{read_addr0, read_addr1};
  assign read_data0 = rf_read_data0;
  assign read_data1 = rf_read_data1;
`endif
endmodule
